// File: rtl/adder_sched_pkg.sv
// Shared parameters and helpers for the round-robin scheduled wide adder.
package adder_sched_pkg;

  localparam int unsigned ADDER_WIDTH_DEFAULT = 148;
  localparam int unsigned NUM_REQ_DEFAULT     = 4;

  // Requester ID width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // LSB of requester i's slice within a packed operand bus of width w per requester.
  function automatic int unsigned op_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: priority starts just after the last grant and wraps.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int unsigned N = NUM_REQ_DEFAULT,
  localparam int unsigned ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic            en,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = ID_W'((32'(last) + k) % N);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_id     = idx;
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one registered adder among NUM_REQ requesters through a round-robin
// arbiter and a two-stage (operand, sum) pipeline with a valid/ready response.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int unsigned ADDER_WIDTH = ADDER_WIDTH_DEFAULT,
  parameter int unsigned NUM_REQ     = NUM_REQ_DEFAULT,
  localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [ADDER_WIDTH:0]           rsp_sum
);

  logic                   s1_valid;
  logic [ID_W-1:0]        s1_id;
  logic [ADDER_WIDTH-1:0] a_reg;
  logic [ADDER_WIDTH-1:0] b_reg;
  logic [ID_W-1:0]        last_grant;

  logic                   s2_adv;
  logic                   s1_adv;
  logic [NUM_REQ-1:0]     gnt;
  logic [ID_W-1:0]        gnt_id;
  logic                   accept;
  logic [ADDER_WIDTH-1:0] a_sel;
  logic [ADDER_WIDTH-1:0] b_sel;

  assign s2_adv    = !rsp_valid || rsp_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign req_ready = gnt;
  assign accept    = |gnt;

  // Grants are suppressed during reset so req_ready reads zero immediately.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req_valid),
    .en     (s1_adv && !rst),
    .last   (last_grant),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // One-hot AND-OR select of the granted requester's operands.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = a_sel | req_a[op_lsb(i, ADDER_WIDTH) +: ADDER_WIDTH];
        b_sel = b_sel | req_b[op_lsb(i, ADDER_WIDTH) +: ADDER_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      last_grant <= gnt_id;
    end
  end

  // Operand stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_id <= gnt_id;
        a_reg <= a_sel;
        b_reg <= b_sel;
      end
    end
  end

  // Sum stage; holds while the consumer back-pressures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
    end else if (s2_adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id  <= s1_id;
        rsp_sum <= {1'b0, a_reg} + {1'b0, b_reg};
      end
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Randomized and directed bench for adder_rr_scheduler against a queue-based reference model.
module tb_adder_rr_scheduler;

  localparam int unsigned W    = adder_sched_pkg::ADDER_WIDTH_DEFAULT;
  localparam int unsigned N    = adder_sched_pkg::NUM_REQ_DEFAULT;
  localparam int unsigned ID_W = adder_sched_pkg::id_width(N);

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a;
  logic [N*W-1:0]    req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [W:0]        rsp_sum;

  adder_rr_scheduler #(.ADDER_WIDTH(W), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected result in flight; at_out marks the one visible on the response port.
  typedef struct {
    int         id;
    logic [W:0] sum;
    bit         at_out;
  } exp_t;

  exp_t          q[$];
  int            m_last;
  logic [W-1:0]  op_a [N];
  logic [W-1:0]  op_b [N];
  int            n_checks;
  int            n_errors;
  int            last_acc;
  int            dut_acc_cnt;
  int            acc_log[$];

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r = {r[W-33:0], 32'($urandom)};
    if ($urandom_range(0, 7) == 0) r = '1;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_last = N - 1;
  endtask

  // One cycle: drive at negedge, check at negedge+1, advance the model at posedge.
  task automatic step(input logic [N-1:0] v, input logic rr);
    int           gid;
    logic [N-1:0] eg;
    exp_t         e;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
    #1;
    gid = -1;
    if (q.size() < 2 || rr) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (gid < 0 && v[idx]) gid = idx;
      end
    end
    eg = '0;
    if (gid >= 0) eg[gid] = 1'b1;
    check("req_ready", 160'(req_ready), 160'(eg));
    if (|(req_valid & req_ready)) dut_acc_cnt++;
    for (int i = 0; i < N; i++) if (req_ready[i]) acc_log.push_back(i);
    if (q.size() > 0 && q[0].at_out) begin
      check("rsp_valid", 160'(rsp_valid), 160'(1));
      check("rsp_id", 160'(rsp_id), 160'(q[0].id));
      check("rsp_sum", 160'(rsp_sum), 160'(q[0].sum));
    end else begin
      check("rsp_valid", 160'(rsp_valid), 160'(0));
    end
    @(posedge clk);
    if (q.size() > 0 && q[0].at_out && rr) void'(q.pop_front());
    if (q.size() > 0 && !q[0].at_out) q[0].at_out = 1'b1;
    last_acc = gid;
    if (gid >= 0) begin
      e.id     = gid;
      e.sum    = {1'b0, op_a[gid]} + {1'b0, op_b[gid]};
      e.at_out = 1'b0;
      q.push_back(e);
      m_last = gid;
      op_a[gid] = rand_op();
      op_b[gid] = rand_op();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [W:0]   e_sum;
    logic [N-1:0] pending;
    n_checks = 0;
    n_errors = 0;
    dut_acc_cnt = 0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = rand_op();
      op_b[i] = rand_op();
    end
    req_a = '0;
    req_b = '0;
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    model_reset();
    #3;
    check("rst_req_ready", 160'(req_ready), 160'(0));
    check("rst_rsp_valid", 160'(rsp_valid), 160'(0));
    check("rst_rsp_id", 160'(rsp_id), 160'(0));
    check("rst_rsp_sum", 160'(rsp_sum), 160'(0));
    do_reset();

    // Single request with a carry into bit W.
    op_a[2] = '1;
    op_b[2] = W'(1);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    e_sum = '0;
    e_sum[W] = 1'b1;
    check("single_valid", 160'(rsp_valid), 160'(1));
    check("single_sum", 160'(rsp_sum), 160'(e_sum));
    check("single_id", 160'(rsp_id), 160'(2));
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Full contention from reset: grants rotate 0,1,2,3,...
    do_reset();
    acc_log.delete();
    repeat (8) step('1, 1'b1);
    check("contention_count", 160'(acc_log.size()), 160'(8));
    for (int i = 0; i < acc_log.size(); i++) check("contention_order", 160'(acc_log[i]), 160'(i % N));
    repeat (2) step('0, 1'b1);

    // Back-pressure: only two requests fit while the output is stalled.
    dut_acc_cnt = 0;
    repeat (5) step('1, 1'b0);
    check("bp_accepts", 160'(dut_acc_cnt), 160'(2));
    check("bp_ready_zero", 160'(req_ready), 160'(0));
    step('1, 1'b1);
    check("bp_release_accepts", 160'(dut_acc_cnt), 160'(3));
    repeat (3) step('0, 1'b1);

    // Asynchronous reset with the pipeline full.
    repeat (3) step('1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 160'(rsp_valid), 160'(0));
    check("midrst_req_ready", 160'(req_ready), 160'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step('1, 1'b1);
    check("midrst_first_grant", 160'(last_acc), 160'(0));
    repeat (3) step('0, 1'b1);

    // Sparse requesters 1 and 3 toggling, 0 and 2 idle.
    for (int c = 0; c < 8; c++) step((c % 2 == 0) ? 4'b1010 : 4'b0000, 1'b1);
    for (int c = 0; c < 6; c++) step((c % 3 == 0) ? 4'b0010 : 4'b1000, 1'b1);

    // Zero and all-ones operands.
    op_a[0] = '0;
    op_b[0] = '0;
    step(4'b0001, 1'b1);
    op_a[1] = '1;
    op_b[1] = '1;
    step(4'b0010, 1'b1);
    check("zero_sum", 160'(rsp_sum), 160'(0));
    check("zero_id", 160'(rsp_id), 160'(0));
    step(4'b0000, 1'b1);
    e_sum = '1;
    e_sum[0] = 1'b0;
    check("max_sum", 160'(rsp_sum), 160'(e_sum));
    step(4'b0000, 1'b1);

    // Random traffic: hold until accepted, occasional forfeit, random back-pressure.
    pending = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i]) pending[i] = ($urandom_range(0, 1) == 1);
        else if ($urandom_range(0, 15) == 0) pending[i] = 1'b0;
      end
      step(pending, ($urandom_range(0, 3) != 0));
      if (last_acc >= 0) pending[last_acc] = 1'b0;
    end
    repeat (4) step('0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_rr_scheduler.md
# adder_rr_scheduler

Shares one registered wide adder (`ADDER_WIDTH`-bit operands, `ADDER_WIDTH+1`-bit sum) among `NUM_REQ` requesters. Requests pass through a round-robin arbiter into a two-stage pipeline: an operand register stage, then a sum register stage. Each result is returned with the requester ID on a single valid/ready response port. The block sits between the arithmetic benchmark clients and the adder datapath, and sustains one addition per cycle when the output is not back-pressured.

## Interface
- `ADDER_WIDTH`, 148, operand width in bits.
- `NUM_REQ`, 4, number of requesters (≥1).
- `ID_W`, `max(1, clog2(NUM_REQ))`, requester ID width (derived).

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_ready`  out  `NUM_REQ`  per-requester grant/accept; one-hot or zero.
- `req_a`  in  `NUM_REQ*ADDER_WIDTH`  packed operand A; requester i occupies slice `[i*ADDER_WIDTH +: ADDER_WIDTH]`.
- `req_b`  in  `NUM_REQ*ADDER_WIDTH`  packed operand B; same slicing as `req_a`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  `ID_W`  requester index of the result.
- `rsp_sum`  out  `ADDER_WIDTH+1`  `a + b` including carry-out.

## Operation
- Two pipeline stages:
  - **S1:** `s1_valid`, `s1_id`, `a_reg`, `b_reg`.
  - **S2:** `rsp_valid`, `rsp_id`, `rsp_sum`.
- Stage advance conditions:
  - `s2_adv = !rsp_valid | rsp_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
- **Arbitration:**
  - Active only when `s1_adv` is high. Otherwise `req_ready` is all zero.
  - Priority order starts at `(last_grant+1) mod NUM_REQ` and wraps.
  - The first requester in that order with `req_valid` set receives `req_ready`.
  - `req_ready` is combinational from `req_valid`, `last_grant` and the stall state. No requester may make `req_valid` depend on `req_ready`.
- **Accept:** a transfer occurs on `req_valid[i] & req_ready[i]`. On that edge:
  - S1 loads the operands and `s1_id = i`;
  - `last_grant` is set to `i`.
  - `last_grant` changes only on an accepted transfer.
- **S1 → S2:** when `s2_adv` is high:
  - `rsp_valid <= s1_valid`;
  - if `s1_valid` is set, `rsp_sum <= {1'b0,a_reg} + {1'b0,b_reg}` and `rsp_id <= s1_id`.
- If `s1_adv` is high and no request is granted, S1 loads `s1_valid = 0`.
- **Stall:** while `rsp_valid & !rsp_ready`:
  - S2 holds.
  - A valid S1 holds.
  - An empty S1 may still accept one request.
- **Arithmetic:** unsigned. Carry-out appears in `rsp_sum[ADDER_WIDTH]`. No wrap, no saturation.
- **Requester rules:**
  - Once raised, a requester keeps `req_valid` and its operands stable until accepted.
  - A requester that drops `req_valid` before acceptance simply forfeits; the arbiter never locks on it.

## Timing
- **Reset values:** `req_ready = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_sum = 0`, `s1_valid = 0`, `last_grant = NUM_REQ-1` (requester 0 has first priority).
- **Reset mid-operation:** all in-flight operations are discarded with no response. Outputs take their reset values immediately and asynchronously.
- **Latency:** a request accepted at edge k has `rsp_valid` high after edge k+1, absent stall.
- **Throughput:** one accept per cycle while `rsp_ready` stays high.
- **Output hold:** `rsp_*` stay stable while `rsp_valid & !rsp_ready`.
- **Simultaneous accept and drain:** an edge that drains S2 (`rsp_ready` high) moves S1 into S2 and accepts a new request on that same edge.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,`NUM_REQ-1`,0,…. Worst-case wait is `NUM_REQ-1` accepted transfers.
- **`NUM_REQ = 1`:** `rsp_id` is always 0; the arbiter degenerates to `req_ready[0] = req_valid[0] & s1_adv`.

## Structure
- **Package `adder_sched_pkg`:**
  - `ADDER_WIDTH_DEFAULT = 148`;
  - `NUM_REQ_DEFAULT = 4`;
  - ID width function `id_width(n)`;
  - packed operand slice helper constants.
- **Sub-module `rr_arbiter`** (parameter `N`):
  - inputs: `req[N]`, `en`, `last[ID_W]`;
  - outputs: `gnt[N]` (one-hot), `gnt_id`;
  - purely combinational.
- **Top level:** `last_grant`, both pipeline stages and the single adder.

## Test plan
- **Reset and single request:** reset; requester 2 sends `a = 2^148-1`, `b = 1` → `rsp_valid` after the next edge with `rsp_sum = 2^148` (bit 148 = 1, rest 0) and `rsp_id = 2`.
- **Full contention:** all 4 requesters valid for 8 cycles with `rsp_ready = 1` → accept order 0,1,2,3,0,1,2,3; one response per cycle; each sum correct.
- **Back-pressure:** hold `rsp_ready = 0` for 5 cycles with all requesters valid →
  - exactly 2 requests accepted (S1 and S2 full);
  - `rsp_*` stable;
  - `req_ready` all zero after the second accept;
  - release → the held response drains and a new accept happens on the same edge.
- **Reset with pipeline full:** assert `rst` asynchronously mid-cycle → `rsp_valid` drops immediately; no stale response after release; next grant goes to requester 0.
- **Sparse requests:** requesters 1 and 3 toggle, 0 and 2 idle → grants alternate 1,3; no grant to an idle index; `last_grant` is unchanged in idle cycles.
- **Zero and max operands:** `a = 0`, `b = 0` gives `rsp_sum = 0`; `a = b = 2^148-1` gives `rsp_sum = 2^149-2`.
